// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the register-file writeback arbiter.
//   - writeback source indices (mux select values)
//   - arbiter state enum
//   - bus geometry constants
//   - wrap_inc: next index modulo NUM_REQ
package wb_pkg;

    localparam int NUM_REQ = 6;
    localparam int DATA_W  = 16;
    localparam int RD_W    = 3;

    localparam logic [2:0] WB_SRC_ALU  = 3'd0;
    localparam logic [2:0] WB_SRC_SHF  = 3'd1;
    localparam logic [2:0] WB_SRC_MUL  = 3'd2;
    localparam logic [2:0] WB_SRC_LD   = 3'd3;
    localparam logic [2:0] WB_SRC_LINK = 3'd4;
    localparam logic [2:0] WB_SRC_IMM  = 3'd5;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } wb_state_e;

    // Source indices wrap 5 -> 0; encodings 6 and 7 are never produced.
    function automatic logic [2:0] wrap_inc(input logic [2:0] idx);
        return (idx == WB_SRC_IMM) ? WB_SRC_ALU : idx + 3'd1;
    endfunction

endpackage

// File: rtl/mux81.sv
// mux81: 6-input writeback data multiplexer.
//   din  [6*DATA_W-1:0]  source i data at [DATA_W*i +: DATA_W]
//   sel  [2:0]           source index 0..5
//   dout [DATA_W-1:0]    selected data (zero for unused encodings 6/7)
module mux81 #(
    parameter int DATA_W = 16
) (
    input  logic [6*DATA_W-1:0] din,
    input  logic [2:0]          sel,
    output logic [DATA_W-1:0]   dout
);

    always_comb begin
        case (sel)
            3'd0:    dout = din[0*DATA_W +: DATA_W];
            3'd1:    dout = din[1*DATA_W +: DATA_W];
            3'd2:    dout = din[2*DATA_W +: DATA_W];
            3'd3:    dout = din[3*DATA_W +: DATA_W];
            3'd4:    dout = din[4*DATA_W +: DATA_W];
            3'd5:    dout = din[5*DATA_W +: DATA_W];
            default: dout = '0;
        endcase
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin arbiter for the single register-file write
// port, shared by six writeback sources, with a bounded lock for multi-beat
// writes.
//
// state  | meaning
// IDLE   | round-robin search from ptr over all valid sources
// LOCKED | only the owner may write; lock lasts at most LOCK_MAX beats
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   req_valid/lock    per-source request and "more beats follow"
//   req_data/req_rd   per-source write data and destination register
//   wb_stall          freezes acceptance and all arbitration state
//   req_ready         one-hot combinational accept
//   wb_en/rd/data/sel registered register-file write
//   lock_active       high while in LOCKED
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_REQ  = 6,
    parameter int DATA_W   = 16,
    parameter int RD_W     = 3,
    parameter int LOCK_MAX = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*RD_W-1:0]   req_rd,
    input  logic                      wb_stall,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      wb_en,
    output logic [RD_W-1:0]           wb_rd,
    output logic [DATA_W-1:0]         wb_data,
    output logic [2:0]                wb_sel,
    output logic                      lock_active
);

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_MAX);

    wb_state_e   state_q, state_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [2:0]  owner_q, owner_d;
    logic [3:0]  cnt_q, cnt_d;

    logic              grant_vld;
    logic [2:0]        grant_idx;
    logic [3:0]        cand;
    logic              found;
    logic [DATA_W-1:0] mux_out;

    logic              wb_en_q;
    logic [RD_W-1:0]   wb_rd_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [2:0]        wb_sel_q;

    // Grant depends only on req_valid, state, ptr/owner and wb_stall.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 3'd0;
        found     = 1'b0;
        cand      = 4'd0;
        if (!wb_stall) begin
            if (state_q == LOCKED) begin
                if (req_valid[owner_q]) begin
                    grant_vld = 1'b1;
                    grant_idx = owner_q;
                end
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    cand = {1'b0, ptr_q} + 4'(k);
                    if (cand >= 4'(NUM_REQ)) begin
                        cand = cand - 4'(NUM_REQ);
                    end
                    if (!found && req_valid[cand[2:0]]) begin
                        found     = 1'b1;
                        grant_vld = 1'b1;
                        grant_idx = cand[2:0];
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    mux81 #(.DATA_W(DATA_W)) u_mux (
        .din  (req_data),
        .sel  (grant_idx),
        .dout (mux_out)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (grant_vld) begin
            if (state_q == IDLE) begin
                // With LOCK_MAX=1 the first beat already exhausts the lock.
                if (req_lock[grant_idx] && (LOCK_MAX > 1)) begin
                    state_d = LOCKED;
                    owner_d = grant_idx;
                    cnt_d   = 4'd1;
                end else begin
                    ptr_d = wrap_inc(grant_idx);
                end
            end else begin
                if (!req_lock[owner_q] || (cnt_q + 4'd1 == LOCK_CNT)) begin
                    state_d = IDLE;
                    ptr_d   = wrap_inc(owner_q);
                end else if (cnt_q != LOCK_CNT) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            owner_q <= 3'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            wb_sel_q  <= 3'd0;
        end else begin
            wb_en_q <= grant_vld;
            if (grant_vld) begin
                wb_rd_q   <= req_rd[int'(grant_idx)*RD_W +: RD_W];
                wb_data_q <= mux_out;
                wb_sel_q  <= grant_idx;
            end
        end
    end

    assign wb_en       = wb_en_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign wb_sel      = wb_sel_q;
    assign lock_active = (state_q == LOCKED);

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    localparam int LMAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  req_valid = '0;
    logic [5:0]  req_lock = '0;
    logic [95:0] req_data = '0;
    logic [17:0] req_rd = '0;
    logic        wb_stall = 1'b0;
    logic [5:0]  req_ready;
    logic        wb_en;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic [2:0]  wb_sel;
    logic        lock_active;

    wb_port_arbiter #(.LOCK_MAX(LMAX)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_lock(req_lock),
        .req_data(req_data), .req_rd(req_rd), .wb_stall(wb_stall),
        .req_ready(req_ready), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_sel(wb_sel), .lock_active(lock_active)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Per-source pending requests
    bit          pend [6];
    bit          lk   [6];
    logic [15:0] ld   [6];
    logic [2:0]  lr   [6];

    // Reference model
    bit          m_locked;
    int          m_ptr, m_owner, m_cnt, m_g;
    bit          e_en;
    int          e_sel;
    logic [2:0]  e_rd;
    logic [15:0] e_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int mgrant();
        if (wb_stall) return -1;
        if (m_locked) return pend[m_owner] ? m_owner : -1;
        for (int k = 0; k < 6; k++) begin
            if (pend[(m_ptr + k) % 6]) return (m_ptr + k) % 6;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_ptr = 0; m_owner = 0; m_cnt = 0;
        e_en = 0; e_sel = 0; e_rd = '0; e_data = '0;
    endtask

    task automatic model_accept(input int g);
        if (!m_locked) begin
            if (lk[g] && LMAX > 1) begin
                m_locked = 1; m_owner = g; m_cnt = 1;
            end else begin
                m_ptr = (g + 1) % 6;
            end
        end else if (!lk[g] || m_cnt + 1 == LMAX) begin
            m_locked = 0; m_ptr = (m_owner + 1) % 6;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic newdata(input int i);
        ld[i] = 16'($urandom);
        lr[i] = 3'($urandom_range(0, 7));
    endtask

    task automatic drive();
        for (int i = 0; i < 6; i++) begin
            req_valid[i]       = pend[i];
            req_lock[i]        = lk[i];
            req_data[16*i +: 16] = ld[i];
            req_rd[3*i +: 3]   = lr[i];
        end
    endtask

    task automatic step(input bit [5:0] rearm);
        logic [5:0] exp_ready;
        drive();
        #1;
        m_g = mgrant();
        exp_ready = (m_g >= 0) ? (6'd1 << m_g) : 6'd0;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        @(posedge clk);
        #1;
        if (m_g >= 0) begin
            e_en = 1; e_sel = m_g; e_rd = lr[m_g]; e_data = ld[m_g];
            model_accept(m_g);
            if (rearm[m_g]) newdata(m_g);
            else pend[m_g] = 0;
        end else begin
            e_en = 0;
        end
        check("wb_en", 32'(wb_en), 32'(e_en));
        check("wb_sel", 32'(wb_sel), 32'(e_sel));
        check("wb_rd", 32'(wb_rd), 32'(e_rd));
        check("wb_data", 32'(wb_data), 32'(e_data));
        check("lock_active", 32'(lock_active), 32'(m_locked));
    endtask

    task automatic clear_all();
        for (int i = 0; i < 6; i++) begin
            pend[i] = 0; lk[i] = 0; newdata(i);
        end
    endtask

    int seq1 [7] = '{0, 1, 2, 3, 4, 5, 0};
    int seq3 [5] = '{3, 3, 3, 4, 0};
    int lck3 [5] = '{1, 1, 0, 0, 0};
    int seq4 [5] = '{2, 2, 2, 2, 5};
    int lck4 [5] = '{1, 1, 1, 0, 0};
    int seq5 [3] = '{3, 4, 1};

    initial begin
        clear_all();
        model_reset();
        drive();
        #12;
        check("rst_wb_en", 32'(wb_en), 32'd0);
        check("rst_wb_sel", 32'(wb_sel), 32'd0);
        check("rst_wb_rd", 32'(wb_rd), 32'd0);
        check("rst_wb_data", 32'(wb_data), 32'd0);
        check("rst_lock", 32'(lock_active), 32'd0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        // All six valid, no lock: plain rotation
        for (int i = 0; i < 6; i++) pend[i] = 1;
        for (int i = 0; i < 7; i++) begin
            step(6'h3f);
            check("t1_seq", 32'(wb_sel), 32'(seq1[i]));
        end
        clear_all();

        // Wrap from ptr=5
        pend[4] = 1; step(6'h00);
        pend[1] = 1; pend[5] = 1;
        step(6'h00); check("t2_first", 32'(wb_sel), 32'd5);
        step(6'h00); check("t2_wrap", 32'(wb_sel), 32'd1);
        pend[0] = 1; pend[2] = 1;
        step(6'h00); check("t2_next", 32'(wb_sel), 32'd2);
        step(6'h00); check("t2_last", 32'(wb_sel), 32'd0);
        clear_all();

        // Three-beat lock from source 3 with 0 and 4 waiting
        pend[0] = 1; pend[3] = 1; pend[4] = 1; lk[3] = 1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) lk[3] = 0;
            step(i < 2 ? 6'b001000 : 6'b000000);
            check("t3_seq", 32'(wb_sel), 32'(seq3[i]));
            check("t3_lock", 32'(lock_active), 32'(lck3[i]));
        end
        clear_all();

        // Persistent lock bounded at LOCK_MAX beats
        pend[2] = 1; pend[5] = 1; lk[2] = 1;
        for (int i = 0; i < 5; i++) begin
            step(6'b000100);
            check("t4_seq", 32'(wb_sel), 32'(seq4[i]));
            check("t4_lock", 32'(lock_active), 32'(lck4[i]));
        end
        lk[2] = 0;
        step(6'h00);
        clear_all();

        // Stall freezes everything
        pend[1] = 1; pend[3] = 1; pend[4] = 1;
        wb_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(6'h00);
            check("t5_stall_en", 32'(wb_en), 32'd0);
        end
        wb_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(6'h00);
            check("t5_seq", 32'(wb_sel), 32'(seq5[i]));
        end
        clear_all();

        // Reset in the middle of a lock
        pend[3] = 1; pend[5] = 1; lk[3] = 1;
        step(6'b001000);
        step(6'b001000);
        check("t6_locked", 32'(lock_active), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_rst_en", 32'(wb_en), 32'd0);
        check("t6_rst_sel", 32'(wb_sel), 32'd0);
        check("t6_rst_rd", 32'(wb_rd), 32'd0);
        check("t6_rst_data", 32'(wb_data), 32'd0);
        check("t6_rst_lock", 32'(lock_active), 32'd0);
        @(posedge clk); #1;
        check("t6_hold_en", 32'(wb_en), 32'd0);
        #1 rst_n = 1'b1;
        pend[5] = 1; pend[3] = 1;
        step(6'h00);
        check("t6_first", 32'(wb_sel), 32'd3);
        pend[3] = 1; lk[3] = 0;
        step(6'h00);
        clear_all();

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 6; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1;
                    lk[i] = ($urandom_range(0, 2) == 0);
                    newdata(i);
                end
            end
            wb_stall = ($urandom_range(0, 7) == 0);
            step(6'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Round-robin arbiter that shares the single register-file write port among six writeback sources: ALU, shifter, multiplier, load unit, PC-link, and immediate/MOV. It drives the 3-bit select of an internal 6-way 16-bit writeback multiplexer and accepts requests with a per-source valid/ready handshake. It registers the selected write for the register file. A lock mechanism keeps the port with one source across multi-beat writes, such as load-multiple, and a beat counter bounds how long that lock can last.

## Interface
Parameters:
- NUM_REQ, 6, number of requesters; fixed at 6, the mux width
- DATA_W, 16, write data width
- RD_W, 3, destination register index width
- LOCK_MAX, 8, maximum consecutive beats one locked owner may hold the port (range 1..15)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  6  per-source write request; bit i is source i
- req_lock  input  6  per-source "more beats follow, keep grant"
- req_data  input  96  source i data at [16i+15:16i]
- req_rd  input  18  source i destination at [3i+2:3i]
- wb_stall  input  1  pipeline hold; no acceptance while high
- req_ready  output  6  one-hot combinational accept for the current cycle
- wb_en  output  1  registered register-file write enable
- wb_rd  output  3  registered destination
- wb_data  output  16  registered write data
- wb_sel  output  3  registered index of the source written
- lock_active  output  1  high while in LOCKED state

## Operation
- Source i maps to mux select value i (3'b000..3'b101). Encodings 3'b110 and 3'b111 are never produced.
- Beat accepted in a cycle: req_valid[g] && req_ready[g]. At most one req_ready bit is high in any cycle. req_ready is zero whenever wb_stall=1.
- State machine has two states:
  - IDLE: round-robin search over req_valid, starting at ptr and wrapping modulo 6 (5→0, never 6 or 7). The first valid source g is granted.
    - Accepted beat with req_lock[g]=0: ptr ← (g+1) mod 6, stay IDLE.
    - Accepted beat with req_lock[g]=1: owner ← g, beat_cnt ← 1, go to LOCKED.
  - LOCKED: only the owner is eligible. Other sources get ready=0 even if the owner is idle.
    - Accepted owner beat with lock=0: release to IDLE, ptr ← (owner+1) mod 6.
    - Accepted owner beat with lock=1 and beat_cnt+1 == LOCK_MAX: forced release to IDLE, ptr ← (owner+1) mod 6. The owner must re-arbitrate.
    - Otherwise beat_cnt increments on each accepted beat.
    - Owner valid low: remain LOCKED, no grant, beat_cnt holds.
- beat_cnt is 4 bits and saturates at LOCK_MAX; it never wraps.
- wb_stall=1: no acceptance, and state, ptr, owner and beat_cnt are all frozen.
- On the clock edge after an accepted beat:
  - wb_en ← 1
  - wb_rd ← req_rd[g]
  - wb_data ← mux output for sel=g
  - wb_sel ← g
- With no accepted beat, wb_en ← 0 and wb_rd, wb_data, wb_sel hold their values.

## Timing
- Reset (async assert, sync release): state=IDLE, ptr=0, owner=0, beat_cnt=0, wb_en=0, wb_rd=0, wb_data=0, wb_sel=0, lock_active=0.
- Reset asserted mid-lock aborts the lock immediately. No write is issued for a beat in flight.
- Latency: request to req_ready is 0 cycles, combinational from req_valid, state, ptr and wb_stall. Accept to wb_en is 1 cycle.
- Throughput: one write per cycle, back-to-back beats from the same or different sources.
- req_ready must not depend on req_data or req_rd.
- Sources hold valid, data, rd and lock stable until accepted.
- lock_active is registered and reflects the state, not the next state.

## Structure
- Shared package wb_pkg holds:
  - WB_SRC_ALU=0, WB_SRC_SHF=1, WB_SRC_MUL=2, WB_SRC_LD=3, WB_SRC_LINK=4, WB_SRC_IMM=5
  - the state enum {IDLE, LOCKED}
  - NUM_REQ, DATA_W, RD_W
- One sub-module: the existing 6-input, 16-bit mux81, instantiated with the combinational grant index g as select.
- Round-robin search, lock FSM and output registers live in the top module.

## Test plan
- Reset then all six valid, no lock, no stall → grants 0,1,2,3,4,5,0 on consecutive cycles. wb_sel follows one cycle later, with wb_en=1 each cycle.
- ptr=5 with only sources 1 and 5 valid → 5 granted first, then 1 (wrap). Next search starts at 2.
- Source 3 locked for 3 beats while sources 0 and 4 are valid → three consecutive writes from 3, then 4 granted, then 0. lock_active=1 only for the cycles in LOCKED state.
- LOCK_MAX=4, source 2 holds lock=1 indefinitely → exactly 4 beats from 2, then forced release, then another valid source is granted.
- wb_stall high for 2 cycles with requests pending → req_ready=0 and wb_en=0. Grant order resumes unchanged after the stall.
- rst_n pulled low while LOCKED with a beat pending → all outputs go to reset values immediately. After release, the first grant goes to the lowest valid index starting from 0.
